// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative 32x32 multiply / divide unit for the execute stage.
// Produces a 64-bit {Hi,Lo} result for MULT, MULTU, DIV, DIVU, MADD and MSUB,
// using one shift-add (multiply) or restoring (divide) step per clock.
// Configuration macro: MULDIV_DIV_EN builds the restoring divider; without it,
// DIV/DIVU are accepted and retire immediately, leaving Hi/Lo untouched.
module ex_muldiv_unit (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        StartIn,
   input  logic [2:0]  OpIn,
   input  logic [31:0] AIn,
   input  logic [31:0] BIn,
   input  logic [63:0] HiLoIn,
   input  logic        FlushIn,
   output logic        StallOut,
   output logic        BusyOut,
   output logic        DoneOut,
   output logic [31:0] HiOut,
   output logic [31:0] LoOut
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } stateT;

   localparam logic [2:0] opMult  = 3'd0;
   localparam logic [2:0] opMultu = 3'd1;
   localparam logic [2:0] opDiv   = 3'd2;
   localparam logic [2:0] opDivu  = 3'd3;
   localparam logic [2:0] opMadd  = 3'd4;
   localparam logic [2:0] opMsub  = 3'd5;

   stateT       state;
   stateT       nextState;
   stateT       acceptTarget;

   logic [4:0]  counter;
   logic [2:0]  opReg;
   logic [31:0] aMag;
   logic [31:0] bMag;
   logic        negRes;
   logic [63:0] hiLoAcc;
   logic [63:0] workReg;

   logic        opValid;
   logic        opSigned;
   logic        canAccept;
   logic        accept;
   logic        aNeg;
   logic        bNeg;

   logic [32:0] mulSum;
   logic [63:0] mulNext;
   logic [63:0] stepNext;
   logic [63:0] mulSigned;
   logic [63:0] fixResult;

`ifdef MULDIV_DIV_EN
   logic [31:0] aRaw;
   logic        negRem;
   logic        bZero;
   logic [32:0] divShift;
   logic [33:0] divTrial;
   logic [63:0] divNext;
   logic [31:0] quoFixed;
   logic [31:0] remFixed;
   logic        opRegIsDiv;
`else
   logic        opIsDiv;
`endif

   // Request decode: which opcodes are legal, signedness and operand signs.
   assign opValid   = (OpIn <= opMsub);
   assign opSigned  = (OpIn != opMultu) && (OpIn != opDivu);
   assign canAccept = (state == IDLE) || (state == DONE);
   assign accept    = canAccept & StartIn & opValid & ~FlushIn;
   assign aNeg      = opSigned & AIn[31];
   assign bNeg      = opSigned & BIn[31];

`ifdef MULDIV_DIV_EN
   assign acceptTarget = RUN;
   assign opRegIsDiv   = (opReg == opDiv) || (opReg == opDivu);
`else
   // Without a divider, divisions retire on the accepting edge.
   assign opIsDiv      = (OpIn == opDiv) || (OpIn == opDivu);
   assign acceptTarget = opIsDiv ? DONE : RUN;
`endif

   // State register; reset always returns to IDLE.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic and status outputs; flush aborts RUN/FIX back to IDLE.
   always_comb begin
      nextState = state;
      BusyOut   = 1'b0;
      DoneOut   = 1'b0;
      StallOut  = 1'b0;
      unique case (state)
         IDLE: begin
            nextState = accept ? acceptTarget : IDLE;
         end
         RUN: begin
            BusyOut = 1'b1;
            if (FlushIn) begin
               nextState = IDLE;
            end else if (counter == 5'd31) begin
               nextState = FIX;
            end
         end
         FIX: begin
            BusyOut   = 1'b1;
            nextState = FlushIn ? IDLE : DONE;
         end
         DONE: begin
            DoneOut   = 1'b1;
            nextState = accept ? acceptTarget : IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
      StallOut = BusyOut | (StartIn & opValid & canAccept);
   end

   // One shift-add multiply step: conditionally add the multiplicand into the
   // upper half, then shift the 65-bit {carry, product} right by one.
   always_comb begin
      mulSum  = {1'b0, workReg[63:32]} + (workReg[0] ? {1'b0, aMag} : 33'd0);
      mulNext = {mulSum, workReg[31:1]};
   end

`ifdef MULDIV_DIV_EN
   // One restoring-division step: {remainder, quotient} share workReg; the
   // dividend bit shifted out of the quotient half enters the remainder.
   always_comb begin
      divShift = {workReg[63:32], workReg[31]};
      divTrial = {1'b0, divShift} - {2'b00, bMag};
      if (!divTrial[33]) begin
         divNext = {divTrial[31:0], workReg[30:0], 1'b1};
      end else begin
         divNext = {divShift[31:0], workReg[30:0], 1'b0};
      end
      stepNext = opRegIsDiv ? divNext : mulNext;
   end
`else
   // Only the multiplier iterates when the divider is not built.
   always_comb begin
      stepNext = mulNext;
   end
`endif

   // Final sign correction and accumulation applied on the FIX edge.
   always_comb begin
      mulSigned = negRes ? (64'd0 - workReg) : workReg;
`ifdef MULDIV_DIV_EN
      quoFixed  = negRes ? (32'd0 - workReg[31:0])  : workReg[31:0];
      remFixed  = negRem ? (32'd0 - workReg[63:32]) : workReg[63:32];
`endif
      case (opReg)
         opMadd:  fixResult = hiLoAcc + mulSigned;
         opMsub:  fixResult = hiLoAcc - mulSigned;
`ifdef MULDIV_DIV_EN
         opDiv, opDivu: begin
            if (bZero) begin
               fixResult = {aRaw, 32'hFFFF_FFFF};
            end else begin
               fixResult = {remFixed, quoFixed};
            end
         end
`endif
         default: fixResult = mulSigned;
      endcase
   end

   // Datapath registers: capture on accept, iterate in RUN, publish on FIX.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         counter <= 5'd0;
         opReg   <= 3'd0;
         aMag    <= 32'd0;
         bMag    <= 32'd0;
         negRes  <= 1'b0;
         hiLoAcc <= 64'd0;
         workReg <= 64'd0;
         HiOut   <= 32'd0;
         LoOut   <= 32'd0;
`ifdef MULDIV_DIV_EN
         aRaw    <= 32'd0;
         negRem  <= 1'b0;
         bZero   <= 1'b0;
`endif
      end else begin
         if (accept) begin
            counter <= 5'd0;
            opReg   <= OpIn;
            aMag    <= aNeg ? (32'd0 - AIn) : AIn;
            bMag    <= bNeg ? (32'd0 - BIn) : BIn;
            negRes  <= aNeg ^ bNeg;
            hiLoAcc <= HiLoIn;
`ifdef MULDIV_DIV_EN
            aRaw    <= AIn;
            negRem  <= aNeg;
            bZero   <= (BIn == 32'd0);
            if ((OpIn == opDiv) || (OpIn == opDivu)) begin
               workReg <= {32'd0, (aNeg ? (32'd0 - AIn) : AIn)};
            end else begin
               workReg <= {32'd0, (bNeg ? (32'd0 - BIn) : BIn)};
            end
`else
            workReg <= {32'd0, (bNeg ? (32'd0 - BIn) : BIn)};
`endif
         end else if ((state == RUN) && !FlushIn) begin
            workReg <= stepNext;
            counter <= counter + 5'd1;
         end else if ((state == FIX) && !FlushIn) begin
            HiOut <= fixResult[63:32];
            LoOut <= fixResult[31:0];
         end
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: self-checking bench for ex_muldiv_unit.
// Directed cases plus randomized operations compared with an arithmetic
// reference model; honours MULDIV_DIV_EN in its expectations.
module tb_ex_muldiv_unit;

   logic        Clk = 1'b0;
   logic        Rst_n = 1'b0;
   logic        StartIn = 1'b0;
   logic [2:0]  OpIn = 3'd0;
   logic [31:0] AIn = 32'd0;
   logic [31:0] BIn = 32'd0;
   logic [63:0] HiLoIn = 64'd0;
   logic        FlushIn = 1'b0;
   logic        StallOut;
   logic        BusyOut;
   logic        DoneOut;
   logic [31:0] HiOut;
   logic [31:0] LoOut;

   int          totalCount = 0;
   int          badCount = 0;
   logic [63:0] modelHiLo = 64'd0;

   ex_muldiv_unit dut (
      .Clk(Clk),
      .Rst_n(Rst_n),
      .StartIn(StartIn),
      .OpIn(OpIn),
      .AIn(AIn),
      .BIn(BIn),
      .HiLoIn(HiLoIn),
      .FlushIn(FlushIn),
      .StallOut(StallOut),
      .BusyOut(BusyOut),
      .DoneOut(DoneOut),
      .HiOut(HiOut),
      .LoOut(LoOut)
   );

   // Free-running clock.
   always #5 Clk = ~Clk;

   // Counts one comparison and reports a mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      totalCount++;
      if (observed !== expected) begin
         badCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   // Reference result {Hi,Lo} from plain arithmetic on the architectural rules.
   function automatic logic [63:0] refModel(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] hilo,
                                            input logic [63:0] prev);
      longint sa;
      longint sb;
      int     ia;
      int     ib;
      int     q;
      int     r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         3'd0: return sa * sb;
         3'd1: return {32'd0, a} * {32'd0, b};
         3'd4: return hilo + sa * sb;
         3'd5: return hilo - sa * sb;
         3'd2, 3'd3: begin
`ifdef MULDIV_DIV_EN
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (op == 3'd3) return {a % b, a / b};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            ia = a;
            ib = b;
            q = ia / ib;
            r = ia % ib;
            return {r, q};
`else
            ia = 0; ib = 0; q = 0; r = 0;
            return prev;
`endif
         end
         default: return prev;
      endcase
   endfunction

   // Issues one operation, waits for DoneOut and checks latency, stall and result.
   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [63:0] hilo, input string tag);
      logic [63:0] expRes;
      int expLat;
      int expStall;
      int stallCnt;
      int doneAt;
      expRes   = refModel(op, a, b, hilo, modelHiLo);
      expLat   = 34;
      expStall = 34;
`ifndef MULDIV_DIV_EN
      if (op == 3'd2 || op == 3'd3) begin
         expLat   = 1;
         expStall = 1;
      end
`endif
      @(negedge Clk);
      StartIn = 1'b1;
      OpIn    = op;
      AIn     = a;
      BIn     = b;
      HiLoIn  = hilo;
      #1;
      stallCnt = StallOut ? 1 : 0;
      doneAt   = 0;
      for (int k = 1; k <= 60 && doneAt == 0; k++) begin
         @(negedge Clk);
         StartIn = 1'b0;
         #1;
         if (DoneOut) doneAt = k;
         else if (StallOut) stallCnt++;
      end
      checkOutput({tag, " latency"}, doneAt, expLat);
      checkOutput({tag, " stall"}, stallCnt, expStall);
      checkOutput({tag, " hilo"}, {HiOut, LoOut}, expRes);
      modelHiLo = expRes;
   endtask

   // Main sequence.
   initial begin
      int doneSeen;
      int first;
      int second;
      logic [63:0] exp1;
      logic [63:0] exp2;

      repeat (3) @(negedge Clk);
      #1;
      checkOutput("reset hi", HiOut, 32'd0);
      checkOutput("reset lo", LoOut, 32'd0);
      checkOutput("reset busy", BusyOut, 1'b0);
      checkOutput("reset done", DoneOut, 1'b0);
      checkOutput("reset stall", StallOut, 1'b0);
      Rst_n = 1'b1;

      applyStimulus(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, "multu max");
      checkOutput("multu max const", {HiOut, LoOut}, 64'hFFFF_FFFE_0000_0001);
      applyStimulus(3'd0, 32'hFFFF_FFFD, 32'd5, 64'd0, "mult neg");
      checkOutput("mult neg const", {HiOut, LoOut}, 64'hFFFF_FFFF_FFFF_FFF1);
      applyStimulus(3'd4, 32'd2, 32'd3, 64'h0000_0001_0000_0000, "madd");
      checkOutput("madd const", {HiOut, LoOut}, 64'h0000_0001_0000_0006);
      applyStimulus(3'd2, 32'hFFFF_FFF9, 32'd2, 64'd0, "div neg");
      applyStimulus(3'd3, 32'd10, 32'd0, 64'd0, "divu zero");
      applyStimulus(3'd5, 32'd1, 32'd1, 64'd0, "msub");
      checkOutput("msub const", {HiOut, LoOut}, 64'hFFFF_FFFF_FFFF_FFFF);
      applyStimulus(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, "div ovf");
      applyStimulus(3'd2, 32'hFFFF_FFF9, 32'd0, 64'd0, "div neg zero");

      // Randomized operations, biased towards interesting divisors.
      for (int i = 0; i < 30; i++) begin
         logic [2:0]  rop;
         logic [31:0] ra;
         logic [31:0] rb;
         logic [63:0] rh;
         rop = 3'($urandom_range(0, 5));
         ra  = $urandom;
         rb  = $urandom;
         rh  = {$urandom, $urandom};
         case ($urandom_range(0, 5))
            0: rb = 32'd0;
            1: rb = 32'($urandom_range(1, 20));
            2: rb = 32'hFFFF_FFFF;
            3: ra = 32'h8000_0000;
            default: ;
         endcase
         applyStimulus(rop, ra, rb, rh, "random");
      end

      // Flush on E10 must abort silently and keep the old Hi/Lo.
      applyStimulus(3'd4, 32'd0, 32'd0, 64'h0000_1234_0000_5678, "seed flush");
      @(negedge Clk);
      StartIn = 1'b1; OpIn = 3'd0; AIn = 32'd77; BIn = 32'd99;
      @(negedge Clk);
      StartIn = 1'b0;
      repeat (9) @(negedge Clk);
      FlushIn = 1'b1;
      @(negedge Clk);
      FlushIn = 1'b0;
      #1;
      checkOutput("flush busy", BusyOut, 1'b0);
      doneSeen = 0;
      repeat (40) begin
         @(negedge Clk);
         #1;
         if (DoneOut) doneSeen = 1;
      end
      checkOutput("flush no done", doneSeen, 0);
      checkOutput("flush hilo", {HiOut, LoOut}, 64'h0000_1234_0000_5678);

      // Reset on E10 clears everything.
      applyStimulus(3'd4, 32'd0, 32'd0, 64'h0000_1234_0000_5678, "seed reset");
      @(negedge Clk);
      StartIn = 1'b1; OpIn = 3'd0; AIn = 32'd77; BIn = 32'd99;
      @(negedge Clk);
      StartIn = 1'b0;
      repeat (9) @(negedge Clk);
      Rst_n = 1'b0;
      @(negedge Clk);
      #1;
      checkOutput("midreset hilo", {HiOut, LoOut}, 64'd0);
      checkOutput("midreset busy", BusyOut, 1'b0);
      checkOutput("midreset done", DoneOut, 1'b0);
      checkOutput("midreset stall", StallOut, 1'b0);
      Rst_n = 1'b1;
      modelHiLo = 64'd0;

      // Invalid opcode is ignored entirely.
      @(negedge Clk);
      StartIn = 1'b1; OpIn = 3'd6; AIn = 32'd3; BIn = 32'd4;
      #1;
      checkOutput("invalid stall", StallOut, 1'b0);
      @(negedge Clk);
      #1;
      checkOutput("invalid busy", BusyOut, 1'b0);
      @(negedge Clk);
      StartIn = 1'b0;
      #1;
      checkOutput("invalid done", DoneOut, 1'b0);
      checkOutput("invalid hilo", {HiOut, LoOut}, modelHiLo);

      // Back-to-back MULTU with StartIn held through DONE.
      exp1 = refModel(3'd1, 32'h0001_0003, 32'h0002_0005, 64'd0, modelHiLo);
      exp2 = refModel(3'd1, 32'hDEAD_BEEF, 32'h1234_5678, 64'd0, exp1);
      @(negedge Clk);
      StartIn = 1'b1; OpIn = 3'd1; AIn = 32'h0001_0003; BIn = 32'h0002_0005;
      first = 0;
      second = 0;
      for (int k = 1; k <= 120 && second == 0; k++) begin
         @(negedge Clk);
         #1;
         if (first != 0 && k == first + 1) StartIn = 1'b0;
         if (DoneOut) begin
            if (first == 0) begin
               first = k;
               checkOutput("b2b first hilo", {HiOut, LoOut}, exp1);
               AIn = 32'hDEAD_BEEF;
               BIn = 32'h1234_5678;
            end else begin
               second = k;
            end
         end
      end
      StartIn = 1'b0;
      checkOutput("b2b first latency", first, 34);
      checkOutput("b2b gap", second - first, 34);
      checkOutput("b2b second hilo", {HiOut, LoOut}, exp2);
      modelHiLo = exp2;

      $display("test done: total=%0d bad=%0d", totalCount, badCount);
      $finish;
   end

endmodule
